// File: rtl/nmcu_pkg.sv
// rtl/nmcu_pkg.sv - shared sizes and FSM state type for the systolic tile engine
package nmcu_pkg;
    localparam int DATA_WIDTH = 8;
    localparam int PSUM_WIDTH = 32;
    localparam int PE_ROWS    = 4;
    localparam int PE_COLS    = 4;
    localparam int MAX_K      = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } tile_state_e;
endpackage

// File: rtl/mac_cell.sv
// rtl/mac_cell.sv - one PE: operand/tag forwarding, multiply, load/add/hold accumulate
// Saturating accumulate is built when NMCU_PSUM_SAT_EN is defined.
module mac_cell
    import nmcu_pkg::*;
#(
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH = nmcu_pkg::PSUM_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clr,
    input  logic [DATA_WIDTH+1:0] west,
    input  logic [DATA_WIDTH+1:0] north,
    output logic [DATA_WIDTH+1:0] east,
    output logic [DATA_WIDTH+1:0] south,
    output logic [PSUM_WIDTH-1:0] psum
);
    // Operand bus layout: {valid, first, data}
    logic signed [DATA_WIDTH-1:0]   a_val;
    logic signed [DATA_WIDTH-1:0]   b_val;
    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [PSUM_WIDTH-1:0]   prod_ext;
    logic        [PSUM_WIDTH-1:0]   acc_next;
    logic                           fire;
    logic                           first;

    assign a_val    = west[DATA_WIDTH-1:0];
    assign b_val    = north[DATA_WIDTH-1:0];
    assign fire     = west[DATA_WIDTH+1] & north[DATA_WIDTH+1];
    assign first    = west[DATA_WIDTH] & north[DATA_WIDTH];
    assign prod     = a_val * b_val;
    assign prod_ext = PSUM_WIDTH'(prod);

`ifdef NMCU_PSUM_SAT_EN
    logic [PSUM_WIDTH:0] wide;

    assign wide = {psum[PSUM_WIDTH-1], psum} + {prod_ext[PSUM_WIDTH-1], prod_ext};

    always_comb begin
        acc_next = wide[PSUM_WIDTH-1:0];
        if (wide[PSUM_WIDTH] != wide[PSUM_WIDTH-1]) begin
            acc_next = wide[PSUM_WIDTH] ? {1'b1, {(PSUM_WIDTH-1){1'b0}}}
                                        : {1'b0, {(PSUM_WIDTH-1){1'b1}}};
        end
    end
`else
    assign acc_next = psum + prod_ext;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            east  <= '0;
            south <= '0;
            psum  <= '0;
        end else begin
            east  <= west;
            south <= north;
            if (clr) begin
                psum <= '0;
            end else if (fire) begin
                psum <= first ? prod_ext : acc_next;
            end
        end
    end
endmodule

// File: rtl/systolic_tile_engine.sv
// rtl/systolic_tile_engine.sv - output-stationary systolic tile: skew lines, FSM, drain mux
// NMCU_PSUM_SAT_EN selects saturating accumulation inside mac_cell.
module systolic_tile_engine
    import nmcu_pkg::*;
#(
    parameter int DATA_WIDTH = nmcu_pkg::DATA_WIDTH,
    parameter int PSUM_WIDTH = nmcu_pkg::PSUM_WIDTH,
    parameter int ROWS       = nmcu_pkg::PE_ROWS,
    parameter int COLS       = nmcu_pkg::PE_COLS,
    parameter int MAX_K      = nmcu_pkg::MAX_K,
    parameter int KW         = $clog2(MAX_K + 1),
    parameter int IW         = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start_i,
    input  logic [KW-1:0]              k_len_i,
    input  logic                       op_valid_i,
    output logic                       op_ready_o,
    input  logic [ROWS*DATA_WIDTH-1:0] op_a_i,
    input  logic [COLS*DATA_WIDTH-1:0] op_b_i,
    output logic                       busy_o,
    output logic                       res_valid_o,
    input  logic                       res_ready_i,
    output logic [COLS*PSUM_WIDTH-1:0] res_row_o,
    output logic [IW-1:0]              res_idx_o,
    output logic                       done_o
);
    localparam int FW = $clog2(ROWS + COLS + 1);
    localparam int BW = DATA_WIDTH + 2;

    tile_state_e     state;
    tile_state_e     state_next;
    logic [KW-1:0]   k_len;
    logic [KW-1:0]   beat_cnt;
    logic [FW-1:0]   flush_cnt;
    logic [IW-1:0]   row_idx;
    logic            transfer;
    logic            last_beat;
    logic            flush_done;
    logic            row_last;
    logic            accept;
    logic            zero_start;
    logic            inj_first;

    logic [BW-1:0]         h_bus [ROWS][COLS+1];
    logic [BW-1:0]         v_bus [ROWS+1][COLS];
    logic [PSUM_WIDTH-1:0] psum  [ROWS][COLS];

    assign transfer   = op_valid_i & op_ready_o;
    assign last_beat  = transfer & ((beat_cnt + KW'(1)) == k_len);
    assign flush_done = (flush_cnt == FW'(ROWS + COLS - 1));
    assign row_last   = (row_idx == IW'(ROWS - 1));
    assign accept     = res_valid_o & res_ready_i;
    assign zero_start = (state == IDLE) & start_i & (k_len_i == '0);
    assign inj_first  = transfer & (beat_cnt == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start_i && k_len_i != '0) state_next = FEED;
            FEED:    if (last_beat)                state_next = FLUSH;
            FLUSH:   if (flush_done)               state_next = DRAIN;
            DRAIN:   if (accept && row_last)       state_next = IDLE;
            default:                               state_next = IDLE;
        endcase
    end

    always_comb begin
        op_ready_o  = (state == FEED);
        busy_o      = (state != IDLE);
        res_valid_o = (state == DRAIN);
    end

    // Counters and the registered completion pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_len     <= '0;
            beat_cnt  <= '0;
            flush_cnt <= '0;
            row_idx   <= '0;
            done_o    <= 1'b0;
        end else begin
            done_o <= zero_start | ((state == DRAIN) & accept & row_last);
            if (state == IDLE && start_i) begin
                k_len    <= k_len_i;
                beat_cnt <= '0;
            end else if (transfer) begin
                beat_cnt <= beat_cnt + KW'(1);
            end
            flush_cnt <= (state == FLUSH) ? flush_cnt + FW'(1) : '0;
            if (state != DRAIN) begin
                row_idx <= '0;
            end else if (accept) begin
                row_idx <= row_last ? '0 : row_idx + IW'(1);
            end
        end
    end

    // Row i of A and column j of B enter the array i and j cycles late
    for (genvar i = 0; i < ROWS; i++) begin : g_a_skew
        if (i == 0) begin : g_direct
            assign h_bus[i][0] = {transfer, inj_first, op_a_i[i*DATA_WIDTH +: DATA_WIDTH]};
        end else begin : g_delay
            logic [BW-1:0] sr [i];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < i; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= {transfer, inj_first, op_a_i[i*DATA_WIDTH +: DATA_WIDTH]};
                    for (int s = 1; s < i; s++) sr[s] <= sr[s-1];
                end
            end
            assign h_bus[i][0] = sr[i-1];
        end
    end

    for (genvar j = 0; j < COLS; j++) begin : g_b_skew
        if (j == 0) begin : g_direct
            assign v_bus[0][j] = {transfer, inj_first, op_b_i[j*DATA_WIDTH +: DATA_WIDTH]};
        end else begin : g_delay
            logic [BW-1:0] sr [j];
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int s = 0; s < j; s++) sr[s] <= '0;
                end else begin
                    sr[0] <= {transfer, inj_first, op_b_i[j*DATA_WIDTH +: DATA_WIDTH]};
                    for (int s = 1; s < j; s++) sr[s] <= sr[s-1];
                end
            end
            assign v_bus[0][j] = sr[j-1];
        end
    end

    for (genvar i = 0; i < ROWS; i++) begin : g_row
        for (genvar j = 0; j < COLS; j++) begin : g_col
            mac_cell #(
                .DATA_WIDTH(DATA_WIDTH),
                .PSUM_WIDTH(PSUM_WIDTH)
            ) u_mac (
                .clk  (clk),
                .rst_n(rst_n),
                .clr  (zero_start),
                .west (h_bus[i][j]),
                .north(v_bus[i][j]),
                .east (h_bus[i][j+1]),
                .south(v_bus[i+1][j]),
                .psum (psum[i][j])
            );
        end
    end

    always_comb begin
        res_row_o = '0;
        res_idx_o = row_idx;
        if (state == DRAIN) begin
            for (int j = 0; j < COLS; j++) begin
                res_row_o[j*PSUM_WIDTH +: PSUM_WIDTH] = psum[row_idx][j];
            end
        end
    end
endmodule

// File: tb/tb_systolic_tile_engine.sv
// tb/tb_systolic_tile_engine.sv - scoreboard bench for systolic_tile_engine (32- and 16-bit psum instances)
module tb_systolic_tile_engine;
    localparam int R   = 4;
    localparam int C   = 4;
    localparam int DW  = 8;
    localparam int PW  = 32;
    localparam int MK  = 16;
    localparam int KW  = $clog2(MK + 1);
    localparam int IW  = 2;
`ifdef NMCU_PSUM_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic            clk;
    logic            rst_n;
    logic            start_i;
    logic [KW-1:0]   k_len_i;
    logic            op_valid_i;
    logic [R*DW-1:0] op_a_i;
    logic [C*DW-1:0] op_b_i;
    logic            res_ready_i;
    logic            op_ready_o, busy_o, res_valid_o, done_o;
    logic [C*PW-1:0] res_row_o;
    logic [IW-1:0]   res_idx_o;
    logic            op_ready16, busy16, res_valid16, done16;
    logic [C*16-1:0] res_row16;
    logic [IW-1:0]   res_idx16;

    int a_m [MK][R];
    int b_m [MK][C];
    logic [127:0] q32 [$];
    logic [127:0] q16 [$];
    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;

    systolic_tile_engine #(.DATA_WIDTH(DW), .PSUM_WIDTH(PW), .ROWS(R), .COLS(C), .MAX_K(MK)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready_o), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .busy_o(busy_o), .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_row_o(res_row_o), .res_idx_o(res_idx_o), .done_o(done_o)
    );

    systolic_tile_engine #(.DATA_WIDTH(DW), .PSUM_WIDTH(16), .ROWS(R), .COLS(C), .MAX_K(MK)) dut16 (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .k_len_i(k_len_i),
        .op_valid_i(op_valid_i), .op_ready_o(op_ready16), .op_a_i(op_a_i), .op_b_i(op_b_i),
        .busy_o(busy16), .res_valid_o(res_valid16), .res_ready_i(res_ready_i),
        .res_row_o(res_row16), .res_idx_o(res_idx16), .done_o(done16)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done_o) done_cnt++;

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic longint fold(input longint v, input int w, input bit sat);
        longint mx = (longint'(1) <<< (w - 1)) - 1;
        longint mn = -mx - 1;
        longint r  = v;
        if (sat) return (r > mx) ? mx : ((r < mn) ? mn : r);
        r = r & ((longint'(1) <<< w) - 1);
        if (r > mx) r = r - (longint'(1) <<< w);
        return r;
    endfunction

    task automatic push_expected(input int k);
        logic [127:0] r32, r16;
        longint p, acc32, acc16;
        for (int i = 0; i < R; i++) begin
            r32 = '0;
            r16 = '0;
            for (int j = 0; j < C; j++) begin
                acc32 = 0;
                acc16 = 0;
                for (int kk = 0; kk < k; kk++) begin
                    p = longint'(a_m[kk][i]) * longint'(b_m[kk][j]);
                    acc32 = (kk == 0) ? p : fold(acc32 + p, 32, SAT);
                    acc16 = (kk == 0) ? p : fold(acc16 + p, 16, SAT);
                end
                r32[j*32 +: 32] = acc32[31:0];
                r16[j*16 +: 16] = acc16[15:0];
            end
            q32.push_back(r32);
            q16.push_back(r16);
        end
    endtask

    task automatic drive_beat(input int kk);
        for (int i = 0; i < R; i++) op_a_i[i*DW +: DW] = DW'(a_m[kk][i]);
        for (int j = 0; j < C; j++) op_b_i[j*DW +: DW] = DW'(b_m[kk][j]);
    endtask

    task automatic fill(input int av, input int bv);
        for (int kk = 0; kk < MK; kk++) begin
            for (int i = 0; i < R; i++) a_m[kk][i] = av;
            for (int j = 0; j < C; j++) b_m[kk][j] = bv;
        end
    endtask

    task automatic set_identity();
        for (int kk = 0; kk < MK; kk++) begin
            for (int i = 0; i < R; i++) a_m[kk][i] = (i == kk) ? 1 : 0;
            for (int j = 0; j < C; j++) b_m[kk][j] = kk * C + j + 1;
        end
    endtask

    // bubble: 0 continuous, 1 every other cycle, 2 random; noise holds start_i high while feeding
    task automatic run_tile(input int k, input int bubble, input int bp_row, input bit noise);
        int  sent = 0;
        int  cyc = 0;
        int  flush = 0;
        int  stall = 0;
        int  got_rows = 0;
        int  d0;
        logic xfer;
        check("idle_before", busy_o, 1'b0);
        push_expected(k);
        d0 = done_cnt;
        start_i = 1'b1;
        k_len_i = KW'(k);
        @(posedge clk); #1;
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1'b1);
        while (sent < k && cyc < 400) begin
            start_i    = noise;
            k_len_i    = noise ? '0 : k_len_i;
            op_valid_i = (bubble == 0) ? 1'b1 : (bubble == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
            drive_beat(sent);
            xfer = op_valid_i & op_ready_o;
            @(posedge clk); #1;
            cyc++;
            if (xfer) sent++;
        end
        start_i    = 1'b0;
        op_valid_i = 1'b0;
        check("feed_beats", sent, k);
        while (!res_valid_o && flush < 50) begin
            @(posedge clk); #1;
            flush++;
        end
        check("flush_len", flush, R + C);
        cyc = 0;
        while (got_rows < R && cyc < 200) begin
            if (!res_valid_o) begin
                check("res_valid_held", res_valid_o, 1'b1);
                break;
            end
            res_ready_i = !(got_rows == bp_row && stall < 5);
            check("row32", res_row_o, q32[0]);
            check("row16", res_row16, q16[0]);
            check("row_idx", res_idx_o, got_rows);
            check("done_low", done_o, 1'b0);
            if (res_ready_i) begin
                void'(q32.pop_front());
                void'(q16.pop_front());
                got_rows++;
            end else begin
                stall++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        res_ready_i = 1'b0;
        check("rows_drained", got_rows, R);
        if (bp_row >= 0) check("stall_cycles", stall, 5);
        check("done_pulse", done_o, 1'b1);
        check("idle_after", busy_o, 1'b0);
        @(posedge clk); #1;
        check("done_once", done_o, 1'b0);
        check("done_count", done_cnt - d0, 1);
        q32.delete();
        q16.delete();
    endtask

    initial begin
        int d0;
        rst_n       = 1'b0;
        start_i     = 1'b0;
        k_len_i     = '0;
        op_valid_i  = 1'b0;
        op_a_i      = '0;
        op_b_i      = '0;
        res_ready_i = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_op_ready", op_ready_o, 1'b0);
        check("rst_busy", busy_o, 1'b0);
        check("rst_res_valid", res_valid_o, 1'b0);
        check("rst_done", done_o, 1'b0);
        check("rst_idx", res_idx_o, 0);
        check("rst_row", res_row_o, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        set_identity();
        run_tile(4, 0, -1, 1'b0);
        run_tile(4, 1, -1, 1'b1);
        run_tile(4, 0, 2, 1'b0);

        fill(1, 1);
        run_tile(4, 0, -1, 1'b0);
        fill(2, 2);
        run_tile(1, 0, -1, 1'b0);

        d0 = done_cnt;
        start_i = 1'b1;
        k_len_i = '0;
        @(posedge clk); #1;
        start_i = 1'b0;
        check("k0_done", done_o, 1'b1);
        check("k0_busy", busy_o, 1'b0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            check("k0_no_valid", res_valid_o, 1'b0);
        end
        check("k0_done_count", done_cnt - d0, 1);

        set_identity();
        d0 = done_cnt;
        start_i = 1'b1;
        k_len_i = KW'(4);
        @(posedge clk); #1;
        start_i    = 1'b0;
        op_valid_i = 1'b1;
        drive_beat(0);
        @(posedge clk); #1;
        drive_beat(1);
        @(posedge clk); #1;
        check("mid_feed_busy", busy_o, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_op_ready", op_ready_o, 1'b0);
        check("mrst_busy", busy_o, 1'b0);
        check("mrst_res_valid", res_valid_o, 1'b0);
        check("mrst_done", done_o, 1'b0);
        check("mrst_idx", res_idx_o, 0);
        check("mrst_row", res_row_o, 0);
        op_valid_i = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            check("mrst_idle", {busy_o, res_valid_o}, 2'b00);
        end
        check("mrst_no_done", done_cnt - d0, 0);

        run_tile(4, 0, -1, 1'b0);

        fill(-128, -128);
        run_tile(MK, 0, -1, 1'b0);

        for (int t = 0; t < 2; t++) begin
            for (int kk = 0; kk < MK; kk++) begin
                for (int i = 0; i < R; i++) a_m[kk][i] = int'($urandom_range(0, 255)) - 128;
                for (int j = 0; j < C; j++) b_m[kk][j] = int'($urandom_range(0, 255)) - 128;
            end
            run_tile(int'($urandom_range(1, MK)), 2, int'($urandom_range(0, R - 1)), 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
